// File: rtl/key_debounce_edge.sv
// -----------------------------------------------------------------------------
// key_debounce_edge
//
// Debounces NKEYS independent, asynchronous, bouncing player keys. Each key is
// synchronised through two flops, then filtered by a small per-key FSM that
// accepts a level change only after DEB_CYCLES consecutive stable samples.
// Accepted changes produce one-cycle press/release pulses. A sticky per-key
// pending flag records presses until the consumer acknowledges them.
//
// Ports
//   C            : clock, all state updates on its rising edge
//   clr_n        : synchronous active-low reset
//   key_raw      : raw key inputs (1 = pressed), asynchronous to C
//   ack          : per-key clear of key_pending
//   key_level    : registered debounced key level
//   key_press    : registered one-cycle pulse on each accepted 0->1 change
//   key_release  : registered one-cycle pulse on each accepted 1->0 change
//   key_pending  : sticky press flag, set after key_press, cleared after ack
//   any_press    : OR of key_press
// -----------------------------------------------------------------------------
module key_debounce_edge #(
    parameter int NKEYS      = 4,
    parameter int DEB_CYCLES = 250000,
    parameter int CNT_W      = 18
) (
    input  logic             C,
    input  logic             clr_n,
    input  logic [NKEYS-1:0] key_raw,
    input  logic [NKEYS-1:0] ack,
    output logic [NKEYS-1:0] key_level,
    output logic [NKEYS-1:0] key_press,
    output logic [NKEYS-1:0] key_release,
    output logic [NKEYS-1:0] key_pending,
    output logic             any_press
);

    // Counter value on which the last stable sample is seen; reaching it ends
    // the wait, so the counter never has to wrap.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        UP_STABLE,
        DOWN_WAIT,
        DOWN_STABLE,
        UP_WAIT
    } state_t;

    logic [NKEYS-1:0] sync1;
    logic [NKEYS-1:0] sync2;

    // Two-flop synchroniser: key_raw is asynchronous and only sync2 is used
    // downstream.
    always_ff @(posedge C) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!clr_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < NKEYS; i++) begin : g_key
        state_t           state;
        logic [CNT_W-1:0] cnt;
        logic             level_q;
        logic             press_q;
        logic             release_q;

        always_ff @(posedge C) begin
            if (!clr_n) begin
                state     <= UP_STABLE;
                cnt       <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                // Pulses default low so each accepted edge lasts one cycle.
                press_q   <= 1'b0;
                release_q <= 1'b0;
                unique case (state)
                    UP_STABLE: begin
                        if (sync2[i]) begin
                            state <= DOWN_WAIT;
                            cnt   <= CNT_ONE;
                        end else begin
                            cnt   <= '0;
                        end
                    end
                    DOWN_WAIT: begin
                        if (!sync2[i]) begin
                            // Glitch: abandon the candidate press silently.
                            state <= UP_STABLE;
                            cnt   <= '0;
                        end else if (cnt == CNT_LAST) begin
                            state   <= DOWN_STABLE;
                            cnt     <= '0;
                            level_q <= 1'b1;
                            press_q <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    DOWN_STABLE: begin
                        if (!sync2[i]) begin
                            state <= UP_WAIT;
                            cnt   <= CNT_ONE;
                        end else begin
                            cnt   <= '0;
                        end
                    end
                    UP_WAIT: begin
                        if (sync2[i]) begin
                            state <= DOWN_STABLE;
                            cnt   <= '0;
                        end else if (cnt == CNT_LAST) begin
                            state     <= UP_STABLE;
                            cnt       <= '0;
                            level_q   <= 1'b0;
                            release_q <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    default: begin
                        state <= UP_STABLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end

        assign key_level[i]   = level_q;
        assign key_press[i]   = press_q;
        assign key_release[i] = release_q;
    end

    // Set has priority over ack so a press arriving with an ack is not lost;
    // ack on a clear bit leaves it clear.
    always_ff @(posedge C) begin
        if (!clr_n) begin
            key_pending <= '0;
        end else begin
            key_pending <= (key_pending & ~ack) | key_press;
        end
    end

    assign any_press = |key_press;

endmodule

// File: doc/key_debounce_edge.md
KEY_DEBOUNCE_EDGE -- requirements
Module: key_debounce_edge

Interface
REQ-001 SHALL have parameter NKEYS, default 4, number of independent player keys.
REQ-002 SHALL have parameter DEB_CYCLES, default 250000, consecutive stable cycles required to accept a level change (5 ms at 50 MHz); legal range 2..2^CNT_W-1.
REQ-003 SHALL have parameter CNT_W, default 18, debounce counter width.
REQ-004 SHALL have port C, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port clr_n, input, 1 bit, reset; synchronous and active-low.
REQ-006 SHALL have port key_raw, input, NKEYS bits, asynchronous, bouncing key inputs; 1 = pressed.
REQ-007 SHALL have port ack, input, NKEYS bits, per-key clear of key_pending.
REQ-008 SHALL have port key_level, output, NKEYS bits, debounced key level.
REQ-009 SHALL have port key_press, output, NKEYS bits, one-cycle pulse on each accepted 0->1 transition.
REQ-010 SHALL have port key_release, output, NKEYS bits, one-cycle pulse on each accepted 1->0 transition.
REQ-011 SHALL have port key_pending, output, NKEYS bits, sticky per-key press flag awaiting consumer ack.
REQ-012 SHALL have port any_press, output, 1 bit, OR of key_press.

Function
REQ-013 SHALL pass each key_raw bit through a two-flop synchronizer (sync1, sync2) before any other use.
REQ-014 SHALL run one independent per-key FSM with states UP_STABLE, DOWN_WAIT, DOWN_STABLE and UP_WAIT, plus a CNT_W-bit counter.
REQ-015 SHALL, in UP_STABLE with sync2=1, go to DOWN_WAIT with cnt=1; with sync2=0, stay and hold cnt=0.
REQ-016 SHALL, in DOWN_WAIT with sync2=0 (glitch), return to UP_STABLE with cnt=0 and emit no pulse.
REQ-017 SHALL, in DOWN_WAIT with sync2=1 and cnt<DEB_CYCLES-1, increment cnt.
REQ-018 SHALL, in DOWN_WAIT with sync2=1 and cnt=DEB_CYCLES-1, go to DOWN_STABLE, clear cnt, set key_level=1 and pulse key_press for exactly one cycle.
REQ-019 SHALL make DOWN_STABLE/UP_WAIT mirror REQ-015..018 with the polarity inverted, driving key_level=0 and a key_release pulse.
REQ-020 SHALL give a latency of exactly DEB_CYCLES+2 cycles: key_raw changing before edge k and held stable makes key_level and the pulse visible after edge k+DEB_CYCLES+1.
REQ-021 SHALL register key_level, key_press and key_release (no combinational path from key_raw); any_press MAY be combinational from the registered key_press.
REQ-022 SHALL set key_pending[i] on the cycle after key_press[i] and clear it on the cycle after ack[i]=1.
REQ-023 SHALL let set win when a key_press set and an ack clear of key_pending[i] land on the same edge.
REQ-024 SHALL make ack[i]=1 with key_pending[i]=0 a no-op.
REQ-025 SHALL never let the counter wrap; it saturates its role at DEB_CYCLES-1 by the state transition.
REQ-026 SHALL handle keys fully independently; simultaneous presses on several keys SHALL pulse in the same cycle.
REQ-027 SHALL not allow a key to produce two key_press pulses without an intervening key_release.

Reset
REQ-028 SHALL, on an edge with clr_n=0: sync1=sync2=0, all FSMs to UP_STABLE, cnt=0, key_level=0, key_press=0, key_release=0, key_pending=0, any_press=0.
REQ-029 SHALL let reset override all other inputs, including mid-debounce and mid-hold; a key physically held through reset is re-accepted as a new press DEB_CYCLES+2 cycles after the first clr_n=1 edge.

Verification (DEB_CYCLES=4 override)
REQ-030 SHALL cover clean press: key_raw[0] 0->1 before edge k, held -> key_level[0]=1 and key_press[0]=1 after edge k+5 only; key_pending[0]=1 from edge k+6.
REQ-031 SHALL cover bounce: key_raw[1] toggling 1,0,1,0 on consecutive cycles, then stable 1 -> exactly one key_press[1], 6 cycles after the last toggle; no key_release[1].
REQ-032 SHALL cover release: after REQ-030, key_raw[0]=0 held -> key_release[0] pulse and key_level[0]=0 after 6 edges; key_pending[0] unaffected.
REQ-033 SHALL cover ack collision: ack[2]=1 on the same edge key_pending[2] is set by a new press -> key_pending[2]=1; ack on the next cycle -> key_pending[2]=0.
REQ-034 SHALL cover reset mid-debounce: clr_n=0 for 1 cycle at cnt=2 with key_raw[3]=1 held -> all outputs 0; key_press[3] fires 6 cycles after clr_n returns to 1.
REQ-035 SHALL cover simultaneous keys: key_raw=4'b1111 at edge k -> key_press=4'b1111 and any_press=1 for one cycle after edge k+5.
